// File: rtl/batch_loss_accumulator.sv
// Batch statistics over the per-sample loss stream: mean, min and max of BATCH_SIZE samples,
// handed to the training controller over a valid/ready handshake.
module batch_loss_accumulator #(
  parameter int unsigned BATCH_SIZE = 16,
  parameter int unsigned LOG2_BATCH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           loss_in,
  input  logic                  loss_valid,
  output logic [31:0]           batch_loss,
  output logic [31:0]           min_loss,
  output logic [31:0]           max_loss,
  output logic [LOG2_BATCH:0]   sample_count,
  output logic                  busy,
  output logic                  batch_valid,
  input  logic                  batch_ready,
  output logic                  overrun
);

  typedef enum logic [1:0] {StIdle, StAccum, StDivide, StOutput} state_e;

  localparam logic [LOG2_BATCH:0] LastCount = (LOG2_BATCH + 1)'(BATCH_SIZE - 1);
  localparam logic [LOG2_BATCH:0] CountOne  = (LOG2_BATCH + 1)'(1);

  state_e                 state;
  logic [LOG2_BATCH+31:0] sum;
  logic                   open_batch;

  // start is honoured only while no result is pending; a sample in that cycle is dropped
  assign open_batch = start && (state == StIdle || state == StAccum);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      sum          <= '0;
      batch_loss   <= '0;
      min_loss     <= 32'hFFFF_FFFF;
      max_loss     <= '0;
      sample_count <= '0;
      busy         <= 1'b0;
      batch_valid  <= 1'b0;
      overrun      <= 1'b0;
    end else if (open_batch) begin
      state        <= StAccum;
      sum          <= '0;
      min_loss     <= 32'hFFFF_FFFF;
      max_loss     <= '0;
      sample_count <= '0;
      busy         <= 1'b1;
      overrun      <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (loss_valid) overrun <= 1'b1;
        end
        StAccum: begin
          if (loss_valid) begin
            sum          <= sum + {{LOG2_BATCH{1'b0}}, loss_in};
            sample_count <= sample_count + CountOne;
            if (loss_in < min_loss) min_loss <= loss_in;
            if (loss_in > max_loss) max_loss <= loss_in;
            if (sample_count == LastCount) state <= StDivide;
          end
        end
        StDivide: begin
          batch_loss  <= sum[LOG2_BATCH+31:LOG2_BATCH];
          batch_valid <= 1'b1;
          busy        <= 1'b0;
          state       <= StOutput;
          if (loss_valid) overrun <= 1'b1;
        end
        StOutput: begin
          if (loss_valid) overrun <= 1'b1;
          if (batch_ready) begin
            batch_valid <= 1'b0;
            state       <= StIdle;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_batch_loss_accumulator.sv
// Scoreboard bench: a queue-based batch model predicts each result, a negedge monitor checks
// every completed handshake; directed checks cover reset, timing, abort and overrun.
module tb_batch_loss_accumulator;
  localparam int unsigned BS = 4;
  localparam int unsigned LB = 2;

  typedef struct packed {
    logic [31:0] mean;
    logic [31:0] mn;
    logic [31:0] mx;
    logic [LB:0] cnt;
  } result_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   loss_in = '0;
  logic          loss_valid = 1'b0;
  logic [31:0]   batch_loss, min_loss, max_loss;
  logic [LB:0]   sample_count;
  logic          busy, batch_valid, overrun;
  logic          batch_ready = 1'b0;

  int unsigned   n_vec = 0;
  int unsigned   n_err = 0;
  logic [31:0]   cur[$];
  result_t       exp_q[$];

  batch_loss_accumulator #(.BATCH_SIZE(BS), .LOG2_BATCH(LB)) dut (
    .clk(clk), .rst(rst), .start(start), .loss_in(loss_in), .loss_valid(loss_valid),
    .batch_loss(batch_loss), .min_loss(min_loss), .max_loss(max_loss),
    .sample_count(sample_count), .busy(busy), .batch_valid(batch_valid),
    .batch_ready(batch_ready), .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: mean/min/max straight from the list of accepted samples.
  task automatic model_accept(input logic [31:0] v);
    longint unsigned s;
    result_t r;
    cur.push_back(v);
    if (cur.size() == BS) begin
      s = 0;
      r.mn = 32'hFFFF_FFFF;
      r.mx = 32'h0;
      foreach (cur[i]) begin
        s += longint'(cur[i]);
        if (cur[i] < r.mn) r.mn = cur[i];
        if (cur[i] > r.mx) r.mx = cur[i];
      end
      r.mean = 32'(s / BS);
      r.cnt  = (LB + 1)'(BS);
      exp_q.push_back(r);
      cur.delete();
    end
  endtask

  task automatic open_batch();
    start = 1'b1;
    tick();
    start = 1'b0;
    cur.delete();
  endtask

  task automatic feed(input logic [31:0] v);
    loss_valid = 1'b1;
    loss_in = v;
    model_accept(v);
    tick();
    loss_valid = 1'b0;
  endtask

  task automatic wait_drain(input bit random_ready);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      batch_ready = random_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      n++;
    end
    chk("drain_timeout", 64'(exp_q.size()), 64'd0);
    batch_ready = 1'b0;
  endtask

  always @(negedge clk) begin
    if (batch_valid && batch_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got mean %0h with no batch pending", batch_loss);
      end else begin
        result_t e;
        e = exp_q.pop_front();
        chk("mean", 64'(batch_loss), 64'(e.mean));
        chk("min", 64'(min_loss), 64'(e.mn));
        chk("max", 64'(max_loss), 64'(e.mx));
        chk("count", 64'(sample_count), 64'(e.cnt));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;

    // Reset asserted between edges must act immediately.
    #3 rst = 1'b1;
    #1;
    chk("rst_batch_loss", 64'(batch_loss), 64'h0);
    chk("rst_min", 64'(min_loss), 64'hFFFF_FFFF);
    chk("rst_max", 64'(max_loss), 64'h0);
    chk("rst_count", 64'(sample_count), 64'h0);
    chk("rst_flags", {61'h0, busy, batch_valid, overrun}, 64'h0);
    tick();
    #4 rst = 1'b0;
    tick();

    // Basic batch with ready tied high.
    batch_ready = 1'b1;
    open_batch();
    chk("basic_busy", 64'(busy), 64'h1);
    chk("basic_open_min", 64'(min_loss), 64'hFFFF_FFFF);
    feed(32'd10);
    chk("basic_count1", 64'(sample_count), 64'd1);
    feed(32'd20);
    feed(32'd30);
    feed(32'd44);
    chk("basic_count4", 64'(sample_count), 64'd4);
    chk("basic_minmax", {min_loss, max_loss}, {32'd10, 32'd44});
    chk("basic_valid_n", 64'(batch_valid), 64'h0);
    tick();
    chk("basic_valid_n1", 64'(batch_valid), 64'h1);
    chk("basic_mean", 64'(batch_loss), 64'd26);
    chk("basic_busy_low", 64'(busy), 64'h0);
    tick();
    chk("basic_valid_n2", 64'(batch_valid), 64'h0);
    chk("basic_drained", 64'(exp_q.size()), 64'd0);

    // All-ones samples: the mean must not lose the carry bits of the sum.
    open_batch();
    for (int i = 0; i < BS; i++) feed(32'hFFFF_FFFF);
    wait_drain(1'b0);
    tick();

    // Backpressure: results hold, stray sample and start are ignored but flagged.
    batch_ready = 1'b0;
    open_batch();
    for (int i = 0; i < BS; i++) feed($urandom);
    tick();
    tick();
    chk("bp_valid", 64'(batch_valid), 64'h1);
    held = batch_loss;
    for (int i = 0; i < 5; i++) begin
      loss_valid = (i == 1);
      start = (i == 3);
      tick();
      loss_valid = 1'b0;
      start = 1'b0;
      chk("bp_hold_valid", 64'(batch_valid), 64'h1);
      chk("bp_hold_mean", 64'(batch_loss), 64'(held));
      chk("bp_busy", 64'(busy), 64'h0);
    end
    chk("bp_overrun", 64'(overrun), 64'h1);
    batch_ready = 1'b1;
    tick();
    batch_ready = 1'b0;
    chk("bp_release", 64'(batch_valid), 64'h0);
    chk("bp_drained", 64'(exp_q.size()), 64'd0);

    // Abort: start with a coincident sample restarts the batch and drops that sample.
    open_batch();
    chk("abort_overrun_clr", 64'(overrun), 64'h0);
    feed(32'd5);
    feed(32'd7);
    start = 1'b1;
    loss_valid = 1'b1;
    loss_in = 32'd99;
    tick();
    start = 1'b0;
    loss_valid = 1'b0;
    cur.delete();
    chk("abort_count", 64'(sample_count), 64'h0);
    chk("abort_min", 64'(min_loss), 64'hFFFF_FFFF);
    chk("abort_overrun", 64'(overrun), 64'h0);
    for (int i = 0; i < BS; i++) feed(32'd8);
    wait_drain(1'b0);
    tick();

    // Mid-batch reset, then a stray sample in IDLE.
    open_batch();
    for (int i = 0; i < 3; i++) feed($urandom);
    #2 rst = 1'b1;
    #1;
    cur.delete();
    chk("mid_rst_count", 64'(sample_count), 64'h0);
    chk("mid_rst_busy", 64'(busy), 64'h0);
    #2 rst = 1'b0;
    tick();
    loss_valid = 1'b1;
    loss_in = 32'd3;
    tick();
    loss_valid = 1'b0;
    chk("stray_overrun", 64'(overrun), 64'h1);
    open_batch();
    chk("start_clears_overrun", 64'(overrun), 64'h0);
    for (int i = 0; i < BS; i++) feed(32'(i * 3));
    wait_drain(1'b1);
    tick();

    // Randomised batches with gaps and random backpressure.
    for (int b = 0; b < 25; b++) begin
      open_batch();
      for (int i = 0; i < BS; i++) begin
        int gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick();
        case ($urandom_range(0, 2))
          0: feed($urandom_range(0, 255));
          1: feed($urandom);
          default: feed(32'hFFFF_FFFF - $urandom_range(0, 15));
        endcase
      end
      wait_drain(1'b1);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/batch_loss_accumulator.md
# batch_loss_accumulator

Downstream consumer of the per-sample L1 loss stage. Collects the 32-bit loss value produced on each loss-stage `done` pulse across one training batch of `BATCH_SIZE` samples. Reports the batch-mean loss plus the min/max per-sample loss to the training controller over a valid/ready handshake. Flags samples that arrive while no batch is open.

## Interface
- `BATCH_SIZE`, default 16: samples per batch; must be a power of two, ≥2.
- `LOG2_BATCH`, default 4: log2(`BATCH_SIZE`); must match.
- `clk` input, 1: sole clock; all state updates on the rising edge.
- `rst` input, 1: asynchronous, active-high reset.
- `start` input, 1: opens a new batch; single-cycle pulse.
- `loss_in` input, 32: per-sample loss, unsigned integer; connects to the loss stage `loss` output.
- `loss_valid` input, 1: `loss_in` is valid this cycle; connects to the loss stage `done` output.
- `batch_loss` output, 32: mean loss, `sum >> LOG2_BATCH` (truncating).
- `min_loss` output, 32: smallest `loss_in` accepted in the batch.
- `max_loss` output, 32: largest `loss_in` accepted in the batch.
- `sample_count` output, `LOG2_BATCH+1`: samples accepted in the current batch.
- `busy` output, 1: high in ACCUM and DIVIDE.
- `batch_valid` output, 1: batch results are valid.
- `batch_ready` input, 1: consumer accepts the results.
- `overrun` output, 1: sticky flag; a `loss_valid` arrived outside ACCUM.

## Operation
- Internal `sum` register is 32+`LOG2_BATCH` bits wide and unsigned. It cannot overflow: its maximum is `BATCH_SIZE`·(2^32−1). `batch_loss` always fits in 32 bits.
- **States:** IDLE, ACCUM, DIVIDE, OUTPUT.
- **IDLE:**
  - On `start`: clear `sum` and `sample_count` to 0, set `min_loss` to 0xFFFFFFFF, set `max_loss` to 0, clear `overrun`, go to ACCUM.
  - `loss_valid` without `start` sets `overrun`.
  - `loss_valid` together with `start` is discarded and does not set `overrun`.
- **ACCUM:**
  - On `loss_valid`: `sum += loss_in`, `sample_count += 1`, `min_loss = min(min_loss, loss_in)`, `max_loss = max(max_loss, loss_in)`.
  - If this accept brings `sample_count` to `BATCH_SIZE`, go to DIVIDE.
  - `start` in ACCUM aborts the batch: the same clear as in IDLE, remain in ACCUM. A `loss_valid` in that same cycle is discarded and does not set `overrun`.
- **DIVIDE:**
  - Register `batch_loss <= sum[LOG2_BATCH+31:LOG2_BATCH]`, set `batch_valid`, go to OUTPUT.
  - `loss_valid` sets `overrun`; `start` is ignored.
- **OUTPUT:**
  - `batch_valid` stays high until a cycle with `batch_ready` high. That edge clears `batch_valid` and returns to IDLE.
  - `loss_valid` sets `overrun`; `start` is ignored.
- `batch_loss`, `min_loss`, `max_loss` and `sample_count` hold their values in IDLE until the next `start`.
- **Reset:** asserting `rst` at any time, including mid-batch or mid-handshake, immediately forces IDLE and the following values. Any partial batch is lost.
  - `batch_loss` = 0, `min_loss` = 0xFFFFFFFF, `max_loss` = 0.
  - `sample_count` = 0, `sum` = 0.
  - `busy` = 0, `batch_valid` = 0, `overrun` = 0.

## Timing
- Accept latency: a `loss_valid` sampled at edge k is reflected in `sample_count`, `min_loss` and `max_loss` after edge k.
- Back-to-back `loss_valid` on consecutive cycles is accepted; throughput is one sample per cycle.
- The final sample is accepted at edge N, entering DIVIDE. At edge N+1, `batch_loss` is updated and `batch_valid` rises.
- `batch_ready` may be high before `batch_valid`. The transfer then completes at edge N+2, back in IDLE.
- `busy` rises after the `start` edge and falls after the DIVIDE edge.
- The earliest new `start` is accepted one cycle after the handshake completes.
- All outputs are registered; no combinational path from any input to any output.

## Test plan
- **Reset values:** pulse `rst` asynchronously between clock edges. Outputs take their reset values without waiting for a clock edge: `min_loss`=0xFFFFFFFF, all other outputs 0, state IDLE.
- **Basic batch:** `BATCH_SIZE`=4, `start`, then `loss_in` = 10, 20, 30, 44 on consecutive cycles, `batch_ready` tied high.
  - `batch_loss`=26 (104>>2), `min_loss`=10, `max_loss`=44, `sample_count`=4.
  - `batch_valid` is high for exactly 1 cycle, 1 cycle after the last accept.
- **Max-value sums:** 4 samples of 0xFFFFFFFF → `batch_loss`=0xFFFFFFFF, proving no truncation of `sum`.
- **Backpressure:** hold `batch_ready` low for 5 cycles after `batch_valid` rises.
  - `batch_valid` and results stay stable; inject `loss_valid` → `overrun`=1.
  - `start` pulses in this window are ignored.
  - Raising `batch_ready` returns to IDLE after 1 edge.
- **Abort:** after 2 samples (5, 7), pulse `start` together with `loss_valid` (`loss_in`=99).
  - Counters clear; 99 is not counted; `overrun` stays 0.
  - 4 more samples of 8 → `batch_loss`=8, `min_loss`=`max_loss`=8.
- **Mid-batch reset and stray sample:** assert `rst` after 3 samples → IDLE, `sample_count`=0.
  - `loss_valid` in IDLE without `start` → `overrun`=1.
  - The next `start` clears `overrun` to 0.
